// File: rtl/frame_former_pkg.sv
// rtl/frame_former_pkg.sv - shared constants, state codes and CRC-16/CCITT helper for frame_former
package frame_former_pkg;

  typedef logic [2:0] state_t;

  // FSM state codes; each state names the next byte to be loaded into the output register
  localparam state_t IDLE    = 3'd0;
  localparam state_t SYNC    = 3'd1;
  localparam state_t HDR     = 3'd2;
  localparam state_t PAYLOAD = 3'd3;
  localparam state_t CRC_HI  = 3'd4;
  localparam state_t CRC_LO  = 3'd5;
  localparam state_t GAP     = 3'd6;

  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h1ACFFC1D;
  localparam logic [15:0] CRC_POLY          = 16'h1021;

  // One byte of CRC-16/CCITT, MSB first, no reflection
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data_byte);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data_byte[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                      c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_former_if.sv
// rtl/frame_former_if.sv - payload input and modulator output handshake bundle for frame_former
interface frame_former_if;
  logic       i_start;
  logic [7:0] i_length;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;
  logic       o_frame_done;

  // frame_former side
  modport master (
    input  i_start, i_length, i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_busy, o_frame_done
  );

  // payload source / modulator side
  modport slave (
    output i_start, i_length, i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_busy, o_frame_done
  );
endinterface

// File: rtl/frame_crc16.sv
// rtl/frame_crc16.sv - registered CRC-16/CCITT accumulator with init and enable
module frame_crc16
  import frame_former_pkg::*;
#(
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_init,
  input  logic        i_en,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] crc_q;

  // Reload at frame start, otherwise fold in each accepted payload byte
  always_ff @(posedge i_clk) begin
    if (i_reset)     crc_q <= CRC_INIT;
    else if (i_init) crc_q <= CRC_INIT;
    else if (i_en)   crc_q <= crc16_byte(crc_q, i_data);
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/frame_former.sv
// rtl/frame_former.sv - builds sync/length/payload/CRC frames for the QPSK modulator byte stream
module frame_former
  import frame_former_pkg::*;
#(
  parameter int          SIZE_DATA_BIT = 8,
  parameter logic [31:0] SYNC_WORD     = DEFAULT_SYNC_WORD,
  parameter logic [15:0] CRC_INIT      = 16'hFFFF,
  parameter int          GAP_BYTES     = 2
) (
  input logic           i_clk,
  input logic           i_reset,
  frame_former_if.master bus
);

  // The byte path and interface are fixed at 8 bits
  if (SIZE_DATA_BIT != 8) begin : g_bad_width
    $error("frame_former supports SIZE_DATA_BIT = 8 only");
  end

  localparam logic [3:0] GAP_LAST = 4'(GAP_BYTES - 1);

  state_t      state;
  logic [7:0]  length_q;
  logic [7:0]  cnt;
  logic [3:0]  gap_cnt;
  logic        lo_pending;
  logic [7:0]  data_q;
  logic        valid_q;
  logic [7:0]  sync_byte;
  logic [15:0] crc;
  logic        load_ok;
  logic        accept;
  logic        out_hs;
  logic        crc_init;

  // The output register may take a new byte when empty or when its byte leaves this cycle
  assign load_ok  = !valid_q || bus.i_ready;
  assign out_hs   = valid_q && bus.i_ready;
  assign accept   = bus.i_valid && bus.o_ready;
  assign crc_init = (state == IDLE) && bus.i_start;

  assign bus.o_ready      = (state == PAYLOAD) && load_ok;
  assign bus.o_data       = data_q;
  assign bus.o_valid      = valid_q;
  assign bus.o_busy       = (state != IDLE);
  assign bus.o_frame_done = (state == CRC_LO) && lo_pending && out_hs;

  // Sync word bytes after the first, MSB byte first
  always_comb begin
    sync_byte = SYNC_WORD[31:24];
    case (cnt[1:0])
      2'd1:    sync_byte = SYNC_WORD[23:16];
      2'd2:    sync_byte = SYNC_WORD[15:8];
      2'd3:    sync_byte = SYNC_WORD[7:0];
      default: sync_byte = SYNC_WORD[31:24];
    endcase
  end

  frame_crc16 #(
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_init  (crc_init),
    .i_en    (accept),
    .i_data  (bus.i_data),
    .o_crc   (crc)
  );

  // Frame sequencer and output register; a load always overrides the handshake clear
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      length_q   <= 8'd0;
      cnt        <= 8'd0;
      gap_cnt    <= 4'd0;
      lo_pending <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
    end else begin
      if (out_hs) valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            length_q <= bus.i_length;
            data_q   <= SYNC_WORD[31:24];
            valid_q  <= 1'b1;
            cnt      <= 8'd1;
            state    <= SYNC;
          end
        end
        SYNC: begin
          if (load_ok) begin
            data_q  <= sync_byte;
            valid_q <= 1'b1;
            if (cnt == 8'd3) begin
              cnt   <= 8'd0;
              state <= HDR;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        HDR: begin
          if (load_ok) begin
            data_q  <= length_q;
            valid_q <= 1'b1;
            state   <= (length_q != 8'd0) ? PAYLOAD : CRC_HI;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            data_q  <= bus.i_data;
            valid_q <= 1'b1;
            if (cnt == length_q - 8'd1) begin
              cnt   <= 8'd0;
              state <= CRC_HI;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        CRC_HI: begin
          if (load_ok) begin
            data_q  <= crc[15:8];
            valid_q <= 1'b1;
            state   <= CRC_LO;
          end
        end
        CRC_LO: begin
          // Load the low byte once, then hold here until it has actually left
          if (!lo_pending) begin
            if (load_ok) begin
              data_q     <= crc[7:0];
              valid_q    <= 1'b1;
              lo_pending <= 1'b1;
            end
          end else if (out_hs) begin
            lo_pending <= 1'b0;
            gap_cnt    <= 4'd0;
            state      <= (GAP_BYTES == 0) ? IDLE : GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= 4'd0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
